// File: rtl/crc4_framer_if.sv
// crc4_framer_if: valid/ready word stream into the framer
interface crc4_framer_if #(
    parameter int DATA_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/crc4_framer.sv
// crc4_framer: serializes words MSB first into tx and an external CRC-3 generator, then appends the remainder
module crc4_framer #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    crc4_framer_if.slave  s,
    output logic          crc_rst_n,
    output logic          crc_wr_en,
    output logic          crc_data_in,
    input  logic [2:0]    crc_word,
    output logic          tx_valid,
    output logic          tx_data,
    output logic          tx_sof,
    output logic          tx_crc
);
    localparam int CW = DATA_W > 3 ? $clog2(DATA_W) : 2;

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, WAIT, AUG, CAPT, CRC} state_t;

    state_t            state;
    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     cnt;
    logic              last_q;
    logic [2:0]        crc_q;
    logic              acc;

    assign acc = s.s_valid && s.s_ready;

    // frame sequencer; every output is set on the edge that enters the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh          <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            crc_q       <= 3'b000;
            s.s_ready   <= 1'b0;
            crc_rst_n   <= 1'b0;
            crc_wr_en   <= 1'b0;
            crc_data_in <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 1'b0;
            tx_sof      <= 1'b0;
            tx_crc      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s.s_ready <= ~acc;
                    crc_rst_n <= ~acc;
                    if (acc) begin
                        sh     <= s.s_data;
                        last_q <= s.s_last;
                        state  <= CLR;
                    end
                end
                CLR: begin
                    crc_rst_n   <= 1'b1;
                    tx_valid    <= 1'b1;
                    tx_sof      <= 1'b1;
                    crc_wr_en   <= 1'b1;
                    tx_data     <= sh[DATA_W-1];
                    crc_data_in <= sh[DATA_W-1];
                    sh          <= sh << 1;
                    cnt         <= CW'(DATA_W - 1);
                    state       <= SHIFT;
                end
                SHIFT: begin
                    tx_sof <= 1'b0;
                    if (cnt == '0) begin
                        tx_valid    <= 1'b0;
                        tx_data     <= 1'b0;
                        crc_data_in <= 1'b0;
                        crc_wr_en   <= last_q;
                        s.s_ready   <= ~last_q;
                        cnt         <= CW'(2);
                        state       <= last_q ? AUG : WAIT;
                    end else begin
                        tx_data     <= sh[DATA_W-1];
                        crc_data_in <= sh[DATA_W-1];
                        sh          <= sh << 1;
                        cnt         <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (acc) begin
                        s.s_ready   <= 1'b0;
                        tx_valid    <= 1'b1;
                        crc_wr_en   <= 1'b1;
                        tx_data     <= s.s_data[DATA_W-1];
                        crc_data_in <= s.s_data[DATA_W-1];
                        sh          <= s.s_data << 1;
                        last_q      <= s.s_last;
                        cnt         <= CW'(DATA_W - 1);
                        state       <= SHIFT;
                    end
                end
                AUG: begin
                    if (cnt == '0) begin
                        crc_wr_en <= 1'b0;
                        state     <= CAPT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPT: begin
                    tx_valid <= 1'b1;
                    tx_crc   <= 1'b1;
                    tx_data  <= crc_word[2];
                    crc_q    <= {crc_word[1:0], 1'b0};
                    cnt      <= CW'(2);
                    state    <= CRC;
                end
                CRC: begin
                    if (cnt == '0) begin
                        tx_valid  <= 1'b0;
                        tx_crc    <= 1'b0;
                        tx_data   <= 1'b0;
                        s.s_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tx_data <= crc_q[2];
                        crc_q   <= crc_q << 1;
                        cnt     <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/crc4_framer.md
Name: crc4_framer

Overview:
- Serializing framer that sits directly upstream of the 3-bit CRC generator (polynomial x^3+x+1, shift-in MSB first, remainder register crc_word).
- Accepts parallel words on a valid/ready stream and shifts them out MSB first, both to the serial line and to the generator's wr_en/data_in inputs.
- After the frame it clocks 3 zero augmentation bits into the generator, captures the remainder, and appends it as 3 trailing bits.
- Clears the generator before every frame through a registered crc_rst_n strobe.

Parameters:
DATA_W, 8, width of input word in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input word valid
s_ready  output  1  framer can accept a word
s_data  input  DATA_W  input word, transmitted MSB first
s_last  input  1  qualifies s_data as the final word of the frame
crc_rst_n  output  1  registered active-low clear to CRC generator rst_n
crc_wr_en  output  1  CRC generator shift enable
crc_data_in  output  1  CRC generator serial data
crc_word  input  3  CRC generator remainder
tx_valid  output  1  tx_data carries a frame bit this cycle
tx_data  output  1  serial output bit
tx_sof  output  1  first bit of frame (with tx_valid)
tx_crc  output  1  tx_data is a CRC bit (with tx_valid)

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low on rst_n.
  - Reset values: state=IDLE, s_ready=0, crc_rst_n=0, crc_wr_en=0, crc_data_in=0, tx_valid=0, tx_data=0, tx_sof=0, tx_crc=0.
  - First edge after release: crc_rst_n=1, s_ready=1.
- All outputs are registered. An output value applies for the whole cycle after the edge that sets it.
- The generator samples crc_wr_en/crc_data_in at the end of that cycle.
- States:
  - IDLE:
    - s_ready=1.
    - On s_valid&&s_ready: load the shift register with s_data, latch s_last into last_q -> CLR.
  - CLR:
    - One cycle, crc_rst_n=0, s_ready=0.
    - -> SHIFT with bit counter = DATA_W-1.
  - SHIFT:
    - Each cycle: tx_valid=1, crc_wr_en=1, tx_data=crc_data_in=shift MSB.
    - tx_sof=1 only on the first bit of the frame.
    - Shift left, decrement counter.
    - After bit 0: last_q=1 -> AUG (count 2); last_q=0 -> WAIT.
  - WAIT:
    - s_ready=1, tx_valid=0, crc_wr_en=0. The generator holds.
    - On s_valid&&s_ready: load word and s_last -> SHIFT. No CLR; the CRC continues.
    - Waits indefinitely; no timeout.
  - AUG:
    - 3 cycles: crc_wr_en=1, crc_data_in=0, tx_valid=0.
    - -> CAPT.
  - CAPT:
    - 1 cycle, crc_wr_en=0.
    - crc_word now holds the remainder; capture it into crc_q.
    - -> CRC (count 2).
  - CRC:
    - 3 cycles: tx_valid=1, tx_crc=1, tx_data=crc_q[2], then [1], then [0]. crc_wr_en=0.
    - -> IDLE.
- s_ready is 0 in CLR, SHIFT, AUG, CAPT and CRC. s_valid is ignored there, and s_data/s_last may change freely.
- Frame length: 1 + N*DATA_W + 3 + 1 + 3 cycles from IDLE accept to IDLE, plus any WAIT stall cycles.
- The tx bit stream is contiguous within a word. Gaps occur only in WAIT, AUG and CAPT, always with tx_valid=0.
- Back-to-back frames: IDLE accepts on its first cycle. A new frame always passes through CLR, so no CRC state carries over.
- s_valid with s_last=1 on the first word gives a single-word frame.
- Reset mid-frame: all state and outputs return to reset values immediately. The partial frame is dropped, with no CRC emitted. crc_rst_n=0 also clears the generator.
- No backpressure on tx; downstream must consume every tx_valid bit.

Test Plan:
- Single word 0x80, s_last=1 (DATA_W=8) -> tx bits 1,0,0,0,0,0,0,0 with tx_sof on the first; crc_word=3'b011 in CAPT; CRC bits 0,1,1 with tx_crc=1; 16 cycles accept->IDLE.
- Single word 0x01 -> CRC bits 0,1,1. Single word 0x00 -> CRC bits 0,0,0, and crc_rst_n low for exactly 1 cycle before the first bit.
- Two-word frame 0x80 then 0x00, with s_valid for word 2 deasserted 5 cycles in WAIT -> tx_valid=0 and crc_wr_en=0 during the stall, 16 data bits, CRC bits 1,1,0.
- Back-to-back frames 0x80(last) then 0x01(last) -> second frame re-clears the generator; both CRCs are 011; s_ready is asserted only in IDLE/WAIT.
- rst_n asserted mid-SHIFT of frame 0x80 -> all outputs 0 asynchronously, no CRC bits; next frame 0x00 after release yields CRC 000.
- s_valid held high with changing s_data throughout SHIFT/AUG/CRC -> no extra word accepted; only words presented while s_ready=1 are transmitted.
